load_store_unit: RTL and testbench

- Memory-access stage directly downstream of the execute stage.
- Accepts one decoded/executed op per handshake: ALU result as address or pass-through value, store data, mem_ren/mem_wen, wmask, load_ctrl.
- Performs load/store over an AXI4-Lite-style master port, aligns and extends load data, and presents one write-back beat to the register-file/WB stage.
- Non-memory ops pass through with one-cycle latency.

---
 rtl/lsu_pkg.sv | 22 ++
 rtl/load_align.sv | 26 ++
 rtl/load_store_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: load_ctrl codes, FSM states and
// the bus response code that counts as success.
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    localparam logic [1:0] OKAY = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        LD_AR,
        LD_R,
        ST_AW_W,
        ST_B,
        DONE
    } lsu_state_e;

endpackage

// File: rtl/load_align.sv
// Moves the addressed byte/halfword of a bus read word down to bit 0 and
// sign- or zero-extends it according to load_ctrl.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  load_ctrl,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {addr, 3'b000};
        case (load_ctrl)
            LB:      data = {{24{shifted[7]}}, shifted[7:0]};
            LH:      data = {{16{shifted[15]}}, shifted[15:0]};
            LBU:     data = {24'b0, shifted[7:0]};
            LHU:     data = {16'b0, shifted[15:0]};
            // lw and every unassigned code take the whole shifted word
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one op per handshake, AXI4-Lite-style load/store, one
// write-back beat. Define LSU_ALIGN_CHECK_EN to fault misaligned accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int         DATA_WIDTH = 32,
    parameter logic [1:0] OKAY_RESP  = OKAY
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  mem_ren,
    input  logic                  mem_wen,
    input  logic [3:0]            wmask,
    input  logic [2:0]            load_ctrl,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic                  reg_wen_in,
    output logic [DATA_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [DATA_WIDTH-1:0] awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [3:0]            wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    output logic                  wb_valid,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  wb_wen,
    output logic                  lsu_err
);

    lsu_state_e            state_q, state_d;
    logic                  in_ready_q, in_ready_d;
    logic                  arvalid_q, arvalid_d, rready_q, rready_d;
    logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic                  wb_valid_q, wb_valid_d, wb_wen_q, wb_wen_d, lsu_err_q, lsu_err_d;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d, araddr_q, araddr_d, awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [1:0]            addr_lo_q, addr_lo_d;
    logic [2:0]            load_ctrl_q, load_ctrl_d;
    logic                  reg_wen_q, reg_wen_d, mem_wen_q, mem_wen_d;
    logic [31:0]           load_data;
    logic                  misaligned, rd_err, wr_err;

    load_align u_align (
        .rdata     (rdata),
        .addr      (addr_lo_q),
        .load_ctrl (load_ctrl_q),
        .data      (load_data)
    );

`ifdef LSU_ALIGN_CHECK_EN
    // Store width comes from wmask, load width from load_ctrl; stores win.
    always_comb begin
        misaligned = 1'b0;
        if (mem_wen) begin
            misaligned = (wmask == 4'b0011 && alu_result[0]) ||
                         (wmask == 4'b1111 && alu_result[1:0] != 2'b00);
        end else if (mem_ren) begin
            case (load_ctrl)
                LB, LBU: misaligned = 1'b0;
                LH, LHU: misaligned = alu_result[0];
                default: misaligned = (alu_result[1:0] != 2'b00);
            endcase
        end
    end
`else
    assign misaligned = 1'b0;
`endif

    assign rd_err = (rresp != OKAY_RESP);
    assign wr_err = (bresp != OKAY_RESP);

    always_comb begin
        state_d     = state_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        wb_valid_d  = 1'b0;
        wb_wen_d    = wb_wen_q;
        lsu_err_d   = lsu_err_q;
        wb_data_d   = wb_data_q;
        araddr_d    = araddr_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        addr_lo_d   = addr_lo_q;
        load_ctrl_d = load_ctrl_q;
        reg_wen_d   = reg_wen_q;
        mem_wen_d   = mem_wen_q;
        case (state_q)
            IDLE: if (in_valid && in_ready_q) begin
                addr_lo_d   = alu_result[1:0];
                load_ctrl_d = load_ctrl;
                reg_wen_d   = reg_wen_in;
                mem_wen_d   = mem_wen;
                if ((mem_wen || mem_ren) && misaligned) begin
                    state_d    = DONE;
                    wb_valid_d = 1'b1;
                    wb_wen_d   = 1'b0;
                    lsu_err_d  = 1'b1;
                end else if (mem_wen) begin
                    state_d   = ST_AW_W;
                    awaddr_d  = {alu_result[DATA_WIDTH-1:2], 2'b00};
                    wdata_d   = store_data << {alu_result[1:0], 3'b000};
                    wstrb_d   = wmask << alu_result[1:0];
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                end else if (mem_ren) begin
                    state_d   = LD_AR;
                    araddr_d  = {alu_result[DATA_WIDTH-1:2], 2'b00};
                    arvalid_d = 1'b1;
                end else begin
                    state_d    = DONE;
                    wb_valid_d = 1'b1;
                    wb_data_d  = alu_result;
                    wb_wen_d   = reg_wen_in;
                    lsu_err_d  = 1'b0;
                end
            end
            LD_AR: if (arready) begin
                arvalid_d = 1'b0;
                rready_d  = 1'b1;
                state_d   = LD_R;
            end
            LD_R: if (rvalid) begin
                rready_d   = 1'b0;
                wb_data_d  = load_data;
                lsu_err_d  = rd_err;
                wb_wen_d   = reg_wen_q && !mem_wen_q && !rd_err;
                wb_valid_d = 1'b1;
                state_d    = DONE;
            end
            ST_AW_W: begin
                // AW and W retire independently; leave once neither is pending
                if (awready) awvalid_d = 1'b0;
                if (wready)  wvalid_d  = 1'b0;
                if ((awready || !awvalid_q) && (wready || !wvalid_q)) begin
                    bready_d = 1'b1;
                    state_d  = ST_B;
                end
            end
            ST_B: if (bvalid) begin
                bready_d   = 1'b0;
                lsu_err_d  = wr_err;
                wb_wen_d   = reg_wen_q && !mem_wen_q && !wr_err;
                wb_valid_d = 1'b1;
                state_d    = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_wen_q    <= 1'b0;
            lsu_err_q   <= 1'b0;
            wb_data_q   <= '0;
            araddr_q    <= '0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            addr_lo_q   <= '0;
            load_ctrl_q <= '0;
            reg_wen_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            wb_valid_q  <= wb_valid_d;
            wb_wen_q    <= wb_wen_d;
            lsu_err_q   <= lsu_err_d;
            wb_data_q   <= wb_data_d;
            araddr_q    <= araddr_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            addr_lo_q   <= addr_lo_d;
            load_ctrl_q <= load_ctrl_d;
            reg_wen_q   <= reg_wen_d;
            mem_wen_q   <= mem_wen_d;
        end
    end

    assign in_ready = in_ready_q;
    assign arvalid  = arvalid_q;
    assign rready   = rready_q;
    assign awvalid  = awvalid_q;
    assign wvalid   = wvalid_q;
    assign bready   = bready_q;
    assign wb_valid = wb_valid_q;
    assign wb_wen   = wb_wen_q;
    assign lsu_err  = lsu_err_q;
    assign wb_data  = wb_data_q;
    assign araddr   = araddr_q;
    assign awaddr   = awaddr_q;
    assign wdata    = wdata_q;
    assign wstrb    = wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: a bus slave with random waits plus a
// reference model of the load/store rules; also honours LSU_ALIGN_CHECK_EN.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid = 0, in_ready, mem_ren = 0, mem_wen = 0, reg_wen_in = 0;
    logic [3:0]  wmask = 0;
    logic [2:0]  load_ctrl = 0;
    logic [31:0] alu_result = 0, store_data = 0;
    logic [31:0] araddr, awaddr, wdata, wb_data;
    logic        arvalid, arready = 0, rvalid = 0, rready;
    logic        awvalid, awready = 0, wvalid, wready = 0, bvalid = 0, bready;
    logic [31:0] rdata = 0;
    logic [1:0]  rresp = 0, bresp = 0;
    logic [3:0]  wstrb;
    logic        wb_valid, wb_wen, lsu_err;

    int n_checks = 0;
    int n_fail   = 0;
    int n_ops    = 0;

    always #5 clock = ~clock;

    load_store_unit dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .wmask(wmask), .load_ctrl(load_ctrl),
        .alu_result(alu_result), .store_data(store_data), .reg_wen_in(reg_wen_in),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_wen(wb_wen), .lsu_err(lsu_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference load result: pick the addressed bytes, then extend.
    function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [1:0] off,
                                             input logic [2:0] lc);
        logic [31:0] w;
        int unsigned b, h;
        w = rd >> (8 * off);
        b = w % 256;
        h = w % 65536;
        case (lc)
            3'd0:    return (b >= 128) ? b - 256 : b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic int access_size(input logic st, input logic [3:0] wm, input logic [2:0] lc);
        if (st) return (wm == 4'hF) ? 4 : ((wm == 4'h3) ? 2 : 1);
        if (lc == 3'd0 || lc == 3'd4) return 1;
        if (lc == 3'd1 || lc == 3'd5) return 2;
        return 4;
    endfunction

    task automatic run_op(input logic wen, input logic ren, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [3:0] wm, input logic [2:0] lc,
                          input logic rwen, input logic [31:0] rd, input logic [1:0] resp,
                          input bit zw, input int aw_dly, output int aw_cyc, output int w_cyc);
        bit is_st, is_ld, mis, exp_err, exp_wen;
        bit ar_fired, aw_fired, w_fired;
        int cyc, wait_n, aw_wait, exp_lat;
        int n_ar, n_r, n_aw, n_w, n_b;
        logic [19:0] exp_hs;
        logic [31:0] exp_data;

        is_st = wen;
        is_ld = ren && !wen;
        mis   = 0;
`ifdef LSU_ALIGN_CHECK_EN
        if (is_st || is_ld) mis = (addr % access_size(is_st, wm, lc)) != 0;
`endif
        exp_err  = mis || ((is_st || is_ld) && resp != 2'b00);
        exp_wen  = rwen && !is_st && !exp_err;
        exp_data = is_ld ? ref_load(rd, addr[1:0], lc) : addr;
        exp_lat  = (mis || !(is_st || is_ld)) ? 1 : 3;
        exp_hs   = 20'h0;
        if (is_ld && !mis) exp_hs = 20'h11000;
        if (is_st && !mis) exp_hs = 20'h00111;

        wait_n = 0;
        while (!in_ready && wait_n < 20) begin
            step();
            wait_n++;
        end
        check("accept_ready", in_ready, 1);
        in_valid = 1; mem_wen = wen; mem_ren = ren; alu_result = addr; store_data = sdata;
        wmask = wm; load_ctrl = lc; reg_wen_in = rwen;
        step();
        // scramble the op fields so a missed capture shows up
        in_valid = 0; alu_result = $urandom; store_data = $urandom; wmask = 4'($urandom);
        load_ctrl = 3'($urandom); mem_wen = 1'($urandom); mem_ren = 1'($urandom);
        reg_wen_in = 1'($urandom);

        cyc = 1; aw_wait = aw_dly; aw_cyc = 0; w_cyc = 0;
        ar_fired = 0; aw_fired = 0; w_fired = 0;
        n_ar = 0; n_r = 0; n_aw = 0; n_w = 0; n_b = 0;
        while (!wb_valid && cyc < 200) begin
            if (ar_fired) check("arvalid_drop", arvalid, 0);
            if (aw_fired) check("awvalid_drop", awvalid, 0);
            if (w_fired)  check("wvalid_drop", wvalid, 0);
            if (arvalid) check("araddr", araddr, addr & 32'hFFFF_FFFC);
            if (awvalid) begin
                aw_cyc++;
                check("awaddr", awaddr, addr & 32'hFFFF_FFFC);
            end
            if (wvalid) begin
                w_cyc++;
                check("wdata", wdata, sdata << (8 * addr[1:0]));
                check("wstrb", wstrb, 32'((wm << addr[1:0]) & 4'hF));
            end
            arready = arvalid && (zw || $urandom_range(0, 1) == 1);
            awready = awvalid && aw_wait == 0 && (zw || $urandom_range(0, 1) == 1);
            if (awvalid && aw_wait > 0) aw_wait--;
            wready  = wvalid && (zw || $urandom_range(0, 1) == 1);
            rvalid  = rready && (zw || $urandom_range(0, 1) == 1);
            rdata   = rvalid ? rd : $urandom;
            rresp   = resp;
            bvalid  = bready && (zw || $urandom_range(0, 1) == 1);
            bresp   = resp;
            if (arvalid && arready) begin ar_fired = 1; n_ar++; end
            if (awvalid && awready) begin aw_fired = 1; n_aw++; end
            if (wvalid && wready)   begin w_fired = 1;  n_w++;  end
            if (rvalid && rready) n_r++;
            if (bvalid && bready) n_b++;
            if (!zw) in_valid = 1'($urandom);
            step();
            cyc++;
        end
        in_valid = 0; arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;

        check("wb_valid", wb_valid, 1);
        if (zw && aw_dly == 0) check("latency", cyc, exp_lat);
        check("hs_counts", {n_ar[3:0], n_r[3:0], n_aw[3:0], n_w[3:0], n_b[3:0]}, exp_hs);
        if (!is_st && !mis) check("wb_data", wb_data, exp_data);
        check("wb_wen", wb_wen, exp_wen);
        check("lsu_err", lsu_err, exp_err);
        step();
        check("wb_pulse", wb_valid, 0);
        check("in_ready_back", in_ready, 1);
        n_ops++;
        $display("op %0d: wen=%0b ren=%0b addr=%08h lc=%0d wm=%h resp=%0d -> data=%08h wen=%0b err=%0b cyc=%0d",
                 n_ops, wen, ren, addr, lc, wm, resp, wb_data, wb_wen, lsu_err, cyc);
    endtask

    logic [3:0] wm_tab [3] = '{4'h1, 4'h3, 4'hF};

    initial begin
        int awc, wc, kind;
        logic [1:0] rsp;

        reset = 1'b0;
        #12;
        check("rst_in_ready", in_ready, 0);
        check("rst_valids", {arvalid, rready, awvalid, wvalid, bready, wb_valid, lsu_err, wb_wen}, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_addrs", araddr | awaddr, 0);
        check("rst_wdata", {wdata[27:0], wstrb}, 0);
        step();
        reset = 1'b1;
        step();

        // directed cases
        run_op(0, 0, 32'h1234_5678, 0, 4'h0, 3'd0, 1, 0, 2'b00, 1, 0, awc, wc);
        run_op(0, 1, 32'h8000_0003, 0, 4'h0, 3'd0, 1, 32'h80FF_0000, 2'b00, 1, 0, awc, wc);
        run_op(0, 1, 32'h8000_0002, 0, 4'h0, 3'd5, 1, 32'h80FF_0000, 2'b00, 1, 0, awc, wc);
        run_op(1, 0, 32'h8000_0001, 32'h0000_00AB, 4'h1, 3'd0, 1, 0, 2'b00, 1, 2, awc, wc);
        check("sb_aw_cycles", awc, 3);
        check("sb_w_cycles", wc, 1);
        run_op(0, 1, 32'h8000_0004, 0, 4'h0, 3'd2, 1, 32'hDEAD_BEEF, 2'b10, 1, 0, awc, wc);
        run_op(0, 1, 32'h8000_0002, 0, 4'h0, 3'd2, 1, 32'hCAFE_F00D, 2'b00, 1, 0, awc, wc);
        run_op(1, 1, 32'h8000_0008, 32'h1111_2222, 4'hF, 3'd2, 1, 0, 2'b01, 1, 0, awc, wc);

        // reset while a load waits in the read-data phase
        in_valid = 1; mem_ren = 1; mem_wen = 0; alu_result = 32'h8000_0010; load_ctrl = 3'd2;
        step();
        in_valid = 0; arready = 1;
        step();
        arready = 0;
        check("pre_reset_rready", rready, 1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_outputs", {arvalid, rready, wb_valid, in_ready}, 0);
        step();
        reset = 1'b1;
        step();
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_wb_valid", wb_valid, 0);

        // randomized ops
        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 3);
            rsp  = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_op(kind == 1 || kind == 3, kind == 2 || kind == 3, $urandom, $urandom,
                   wm_tab[$urandom_range(0, 2)], 3'($urandom_range(0, 7)), 1'($urandom),
                   $urandom, rsp, $urandom_range(0, 3) == 0, 0, awc, wc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
